// File: rtl/alu_system_control_unit_if.sv
// Control/status bundle between the ALUSystem sequencer (master) and the datapath (slave).
interface alu_system_control_unit_if;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic        Halted;

  modport master (
    input  IROut, ALUOutFlag,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, Halted
  );

  modport slave (
    output IROut, ALUOutFlag,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, Halted
  );
endinterface

// File: rtl/alu_system_control_unit.sv
// Hardwired fetch/decode/execute sequencer for ALUSystem.
// Optional SINGLE_STEP_EN adds a Step input and a WAIT state after each instruction.
module alu_system_control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic Clock,
  input  logic Reset,
`ifdef SINGLE_STEP_EN
  input  logic Step,
`endif
  alu_system_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT, S_PADJ, S_F0, S_F1, S_DEC, S_EX, S_HLT
`ifdef SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  state_e     after_op;

  logic [3:0] opc;
  logic [1:0] rd, rs;
  logic       unused_bits;

  assign opc = bus.IROut[15:12];
  assign rd  = bus.IROut[11:10];
  assign rs  = bus.IROut[9:8];
  assign unused_bits = ^{bus.IROut[7:0], bus.ALUOutFlag[2:0]};

`ifdef SINGLE_STEP_EN
  assign after_op = S_WAIT;
`else
  assign after_op = S_F0;
`endif

  // Register code 01..11 selects R1..R3, 00 selects R4; RegSel is active-low with R1 at bit 3.
  function automatic logic [3:0] rf_sel(input logic [1:0] c);
    case (c)
      2'd1:    rf_sel = 4'b0111;
      2'd2:    rf_sel = 4'b1011;
      2'd3:    rf_sel = 4'b1101;
      default: rf_sel = 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] alu_fn(input logic [3:0] op);
    case (op)
      4'h4:    alu_fn = 4'b0100;
      4'h5:    alu_fn = 4'b0110;
      4'h6:    alu_fn = 4'b0111;
      4'h7:    alu_fn = 4'b1000;
      4'h8:    alu_fn = 4'b0010;
      4'h9:    alu_fn = 4'b1011;
      4'hA:    alu_fn = 4'b1100;
      default: alu_fn = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bus.RF_OutASel  = 2'b00;
    bus.RF_OutBSel  = 2'b00;
    bus.RF_FunSel   = 2'b00;
    bus.RF_RegSel   = 4'b1111;
    bus.ALU_FunSel  = 4'b0000;
    bus.ARF_OutCSel = 2'b00;
    bus.ARF_OutDSel = 2'b00;
    bus.ARF_FunSel  = 2'b00;
    bus.ARF_RegSel  = 3'b111;
    bus.IR_LH       = 1'b0;
    bus.IR_Enable   = 1'b0;
    bus.IR_Funsel   = 2'b00;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = 2'b00;
    bus.MuxBSel     = 2'b00;
    bus.MuxCSel     = 1'b0;
    bus.Halted      = 1'b0;
    // While Reset is high everything stays idle so an aborted STM never reaches memory.
    if (!Reset) begin
      case (state_q)
        S_INIT: begin
          bus.ARF_RegSel = 3'b110;
          bus.ARF_FunSel = 2'b11;
          cnt_d          = PC_RESET;
          state_d        = (PC_RESET == 8'h00) ? S_F0 : S_PADJ;
        end
        S_PADJ: begin
          bus.ARF_RegSel = 3'b110;
          bus.ARF_FunSel = 2'b01;
          cnt_d          = cnt_q - 8'd1;
          state_d        = (cnt_q == 8'd1) ? S_F0 : S_PADJ;
        end
        S_F0, S_F1: begin
          bus.ARF_OutDSel = 2'b10;
          bus.Mem_CS      = 1'b0;
          bus.IR_Enable   = 1'b1;
          bus.IR_LH       = (state_q == S_F1);
          bus.IR_Funsel   = 2'b10;
          bus.ARF_RegSel  = 3'b110;
          bus.ARF_FunSel  = 2'b01;
          state_d         = (state_q == S_F0) ? S_F1 : S_DEC;
        end
        S_DEC: begin
          bus.MuxBSel    = 2'b10;
          bus.ARF_RegSel = 3'b011;
          bus.ARF_FunSel = 2'b10;
          state_d        = after_op;
          case (opc)
            4'h0: begin
              bus.RF_RegSel = rf_sel(rd);
              bus.RF_FunSel = 2'b10;
              bus.MuxASel   = 2'b10;
            end
            4'h1, 4'h2: state_d = S_EX;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
              // MOV and NOT act on the A port, so RS is routed there instead of RD.
              bus.RF_OutASel = (opc == 4'h3 || opc == 4'h8) ? rs : rd;
              bus.RF_OutBSel = rs;
              bus.ALU_FunSel = alu_fn(opc);
              bus.RF_RegSel  = rf_sel(rd);
              bus.RF_FunSel  = 2'b10;
            end
            4'hB: begin
              bus.RF_RegSel = rf_sel(rd);
              bus.RF_FunSel = 2'b01;
            end
            4'hC: bus.RF_RegSel = rf_sel(rd);
            4'hD: bus.ARF_RegSel = 3'b110;
            4'hE: if (bus.ALUOutFlag[3]) bus.ARF_RegSel = 3'b110;
            default: state_d = S_HLT;
          endcase
        end
        S_EX: begin
          bus.ARF_OutDSel = 2'b00;
          bus.Mem_CS      = 1'b0;
          state_d         = after_op;
          if (opc == 4'h2) begin
            bus.RF_OutASel = rs;
            bus.Mem_WR     = 1'b1;
          end else begin
            bus.MuxASel   = 2'b01;
            bus.RF_RegSel = rf_sel(rd);
            bus.RF_FunSel = 2'b10;
          end
        end
`ifdef SINGLE_STEP_EN
        S_WAIT: if (Step) state_d = S_F0;
`endif
        default: bus.Halted = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Sequencer bench: behavioural ALUSystem datapath around the DUT, instruction-level reference model.
module tb_alu_system_control_unit;
`ifdef SINGLE_STEP_EN
  localparam int WC = 1;
`else
  localparam int WC = 0;
`endif
  localparam int C1 = 3 + WC;
  localparam int C2 = 4 + WC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b1;
  bit   preload = 1'b1;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_system_control_unit_if bus();

  alu_system_control_unit #(.PC_RESET(8'h00)) dut (
    .Clock(clk),
    .Reset(rst),
`ifdef SINGLE_STEP_EN
    .Step(step),
`endif
    .bus(bus)
  );

  // ---------------- datapath model ----------------
  logic [7:0]  init_mem [256];
  logic [7:0]  init_r   [4];
  logic [7:0]  mem [256];
  logic [7:0]  r   [4];
  logic [7:0]  ar, sp, pc;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic [7:0]  out_a, out_b, arf_c, arf_d, alu_a, alu_out, mem_out, mux_a, mux_b;

  function automatic int ri(input logic [1:0] c);
    return (c == 2'd0) ? 3 : int'(c) - 1;
  endfunction

  function automatic logic [7:0] upd(input logic [7:0] v, input logic [1:0] fs, input logic [7:0] d);
    case (fs)
      2'b00:   return v - 8'd1;
      2'b01:   return v + 8'd1;
      2'b10:   return d;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] arf_pick(input logic [1:0] s, input logic [7:0] a,
                                          input logic [7:0] p, input logic [7:0] q);
    case (s)
      2'b00:   return a;
      2'b01:   return p;
      default: return q;
    endcase
  endfunction

  always_comb begin
    out_a = r[ri(bus.RF_OutASel)];
    out_b = r[ri(bus.RF_OutBSel)];
    arf_c = arf_pick(bus.ARF_OutCSel, ar, sp, pc);
    arf_d = arf_pick(bus.ARF_OutDSel, ar, sp, pc);
    alu_a = bus.MuxCSel ? arf_c : out_a;
    case (bus.ALU_FunSel)
      4'b0001: alu_out = out_b;
      4'b0010: alu_out = ~alu_a;
      4'b0011: alu_out = ~out_b;
      4'b0100: alu_out = alu_a + out_b;
      4'b0110: alu_out = alu_a - out_b;
      4'b0111: alu_out = alu_a & out_b;
      4'b1000: alu_out = alu_a | out_b;
      4'b1001: alu_out = alu_a ^ out_b;
      4'b1011: alu_out = {alu_a[6:0], 1'b0};
      4'b1100: alu_out = {1'b0, alu_a[7:1]};
      default: alu_out = alu_a;
    endcase
    mem_out = mem[arf_d];
    case (bus.MuxASel)
      2'b00: mux_a = alu_out; 2'b01: mux_a = mem_out; 2'b10: mux_a = ir[7:0]; default: mux_a = arf_c;
    endcase
    case (bus.MuxBSel)
      2'b00: mux_b = alu_out; 2'b01: mux_b = mem_out; 2'b10: mux_b = ir[7:0]; default: mux_b = arf_c;
    endcase
  end

  assign bus.IROut      = ir;
  assign bus.ALUOutFlag = flags;

  always @(posedge clk) begin
    if (rst) begin
      flags <= 4'h0;
      if (preload) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        for (int i = 0; i < 4; i++) r[i] <= init_r[i];
        ar <= 8'h00; sp <= 8'h00; pc <= 8'h55; ir <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) if (!bus.RF_RegSel[3-i]) r[i] <= upd(r[i], bus.RF_FunSel, mux_a);
      if (!bus.ARF_RegSel[2]) ar <= upd(ar, bus.ARF_FunSel, mux_b);
      if (!bus.ARF_RegSel[1]) sp <= upd(sp, bus.ARF_FunSel, mux_b);
      if (!bus.ARF_RegSel[0]) pc <= upd(pc, bus.ARF_FunSel, mux_b);
      if (bus.IR_Enable && bus.IR_Funsel == 2'b10) begin
        if (bus.IR_LH) ir[15:8] <= mem_out; else ir[7:0] <= mem_out;
      end
      if (!bus.Mem_CS && bus.Mem_WR) mem[arf_d] <= alu_out;
      if (bus.RF_RegSel != 4'b1111 && bus.MuxASel == 2'b00 && bus.RF_FunSel == 2'b10)
        flags <= {alu_out == 8'h00, 1'b0, alu_out[7], 1'b0};
    end
  end

  // ---------------- instruction-level reference ----------------
  logic [7:0] im [256];
  logic [7:0] ireg [4];
  logic [7:0] ipc;
  bit         iz;

  task automatic isa_run(input int k, output int cyc, output bit hlt);
    logic [7:0] p, lo, hi, a, b, res;
    int d, s;
    p = 8'h00; cyc = 0; hlt = 1'b0;
    for (int n = 0; n < k && !hlt; n++) begin
      lo = im[p]; p = p + 8'd1;
      hi = im[p]; p = p + 8'd1;
      d = ri(hi[3:2]); s = ri(hi[1:0]);
      a = ireg[d]; b = ireg[s];
      cyc += C1;
      case (hi[7:4])
        4'h0: ireg[d] = lo;
        4'h1: begin ireg[d] = im[lo]; cyc++; end
        4'h2: begin im[lo] = b; cyc++; end
        4'hB: ireg[d] = a + 8'd1;
        4'hC: ireg[d] = a - 8'd1;
        4'hD: p = lo;
        4'hE: if (iz) p = lo;
        4'hF: begin hlt = 1'b1; cyc -= WC; end
        default: begin
          case (hi[7:4])
            4'h3: res = b;
            4'h4: res = a + b;
            4'h5: res = a - b;
            4'h6: res = a & b;
            4'h7: res = a | b;
            4'h8: res = ~b;
            4'h9: res = a << 1;
            default: res = a >> 1;
          endcase
          ireg[d] = res;
          iz = (res == 8'h00);
        end
      endcase
    end
    ipc = p;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) init_r[i] = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  rsel;
    logic [1:0]  rfun;
    logic [3:0]  alu;
    logic [1:0]  muxa, muxb;
    logic [2:0]  arsel;
    logic [1:0]  oa, ob;
  } vec_t;

  vec_t vt [15];

  initial begin
    int cyc, wr_cnt, bad;
    bit hlt;
    vec_t v;

    vt[0]  = '{16'h0455, 4'b0111, 2'b10, 4'b0000, 2'b10, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[1]  = '{16'h4600, 4'b0111, 2'b10, 4'b0100, 2'b00, 2'b10, 3'b011, 2'b01, 2'b10};
    vt[2]  = '{16'h5B00, 4'b1011, 2'b10, 4'b0110, 2'b00, 2'b10, 3'b011, 2'b10, 2'b11};
    vt[3]  = '{16'h3E00, 4'b1101, 2'b10, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b10, 2'b10};
    vt[4]  = '{16'h6600, 4'b0111, 2'b10, 4'b0111, 2'b00, 2'b10, 3'b011, 2'b01, 2'b10};
    vt[5]  = '{16'h7600, 4'b0111, 2'b10, 4'b1000, 2'b00, 2'b10, 3'b011, 2'b01, 2'b10};
    vt[6]  = '{16'h8C00, 4'b1101, 2'b10, 4'b0010, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[7]  = '{16'h9400, 4'b0111, 2'b10, 4'b1011, 2'b00, 2'b10, 3'b011, 2'b01, 2'b00};
    vt[8]  = '{16'hA400, 4'b0111, 2'b10, 4'b1100, 2'b00, 2'b10, 3'b011, 2'b01, 2'b00};
    vt[9]  = '{16'hB800, 4'b1011, 2'b01, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[10] = '{16'hC400, 4'b0111, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[11] = '{16'hD033, 4'b1111, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b110, 2'b00, 2'b00};
    vt[12] = '{16'hE033, 4'b1111, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[13] = '{16'h1480, 4'b1111, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};
    vt[14] = '{16'hF000, 4'b1111, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b011, 2'b00, 2'b00};

    // Reset, INIT, first fetch and LDI R1,0x2A.
    clear_prog();
    init_mem[0] = 8'h2A; init_mem[1] = 8'h04;
    do_reset();
    chk("init_vec", {bus.ARF_FunSel, bus.ARF_RegSel, bus.Halted, bus.Mem_CS}, {2'b11, 3'b110, 1'b0, 1'b1});
    cycles(1);
    chk("f0_vec", {bus.Mem_CS, bus.ARF_OutDSel, bus.IR_Enable, bus.IR_LH, bus.ARF_FunSel},
        {1'b0, 2'b10, 1'b1, 1'b0, 2'b01});
    cycles(C1);
    chk("ldi_r1", r[0], 8'h2A);
    chk("ldi_pc", pc, 8'h02);
    chk("ldi_back_f0", {bus.IR_Enable, bus.IR_LH}, 2'b10);

    // Decode-cycle control vectors.
    for (int i = 0; i < 15; i++) begin
      v = vt[i];
      clear_prog();
      init_mem[0] = v.instr[7:0]; init_mem[1] = v.instr[15:8];
      do_reset();
      cycles(3);
      chk($sformatf("dec_%04h", v.instr),
          {bus.RF_RegSel, bus.RF_FunSel, bus.ALU_FunSel, bus.MuxASel, bus.MuxBSel,
           bus.ARF_RegSel, bus.RF_OutASel, bus.RF_OutBSel},
          {v.rsel, v.rfun, v.alu, v.muxa, v.muxb, v.arsel, v.oa, v.ob});
    end

    // BEQ taken (5-5) then not taken (5-4).
    for (int k = 0; k < 2; k++) begin
      clear_prog();
      init_mem[0] = 8'h05; init_mem[1] = 8'h04;
      init_mem[2] = (k == 0) ? 8'h05 : 8'h04; init_mem[3] = 8'h08;
      init_mem[4] = 8'h00; init_mem[5] = 8'h56;
      init_mem[6] = 8'h20; init_mem[7] = 8'hE0;
      do_reset();
      cycles(1 + 4 * C1);
      chk($sformatf("beq_pc_%0d", k), pc, (k == 0) ? 8'h20 : 8'h08);
      chk($sformatf("beq_z_%0d", k), flags[3], (k == 0) ? 1'b1 : 1'b0);
    end

    // STM R1,0x80 then LDM R3,0x80.
    clear_prog();
    init_mem[0] = 8'h5C; init_mem[1] = 8'h04;
    init_mem[2] = 8'h80; init_mem[3] = 8'h21;
    init_mem[4] = 8'h80; init_mem[5] = 8'h1C;
    do_reset();
    wr_cnt = 0;
    for (int i = 0; i < 1 + C1 + 2 * C2; i++) begin
      if (bus.Mem_WR && !bus.Mem_CS) wr_cnt++;
      cycles(1);
    end
    chk("stm_wr_cycles", wr_cnt, 1);
    chk("stm_mem", mem[8'h80], 8'h5C);
    chk("ldm_r3", r[2], 8'h5C);

    // HLT at PC=6 holds, then Reset restarts.
    clear_prog();
    init_mem[7] = 8'hF0;
    do_reset();
    cycles(1 + 3 * C1 + 3);
    chk("hlt_enter", {bus.Halted, pc}, {1'b1, 8'h08});
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.Halted || bus.IR_Enable || !bus.Mem_CS) bad++;
      cycles(1);
    end
    chk("hlt_hold", bad, 0);
    do_reset();
    chk("hlt_reset_init", {bus.Halted, bus.ARF_FunSel, bus.ARF_RegSel}, {1'b0, 2'b11, 3'b110});

    // Reset during EX of STM aborts the write.
    clear_prog();
    init_mem[0] = 8'h5C; init_mem[1] = 8'h04;
    init_mem[2] = 8'h80; init_mem[3] = 8'h21;
    init_mem[8'h80] = 8'h11;
    do_reset();
    cycles(1 + C1 + 3);
    chk("stm_ex_reached", {bus.Mem_WR, bus.Mem_CS}, 2'b10);
    preload = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_cs", {bus.Mem_WR, bus.Mem_CS}, 2'b01);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_init", {bus.ARF_FunSel, bus.ARF_RegSel}, {2'b11, 3'b110});
    chk("abort_mem", mem[8'h80], 8'h11);
    preload = 1'b1;

`ifdef SINGLE_STEP_EN
    clear_prog();
    init_mem[0] = 8'h2A; init_mem[1] = 8'h04;
    do_reset();
    step = 1'b0;
    cycles(4);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.IR_Enable || pc != 8'h02) bad++;
      cycles(1);
    end
    chk("step_wait", bad, 0);
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    chk("step_f0", bus.IR_Enable, 1'b1);
    cycles(3);
    chk("step_one_instr", {bus.IR_Enable, pc}, {1'b0, 8'h04});
    step = 1'b1;
`endif

    // Random programs against the instruction-level model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 256; i++) begin
        init_mem[i] = 8'($urandom);
        im[i] = init_mem[i];
      end
      for (int i = 0; i < 4; i++) begin
        init_r[i] = 8'($urandom);
        ireg[i] = init_r[i];
      end
      iz = 1'b0;
      isa_run(15, cyc, hlt);
      do_reset();
      cycles(1 + cyc);
      chk($sformatf("rnd%0d_regs", t), {r[0], r[1], r[2], r[3]}, {ireg[0], ireg[1], ireg[2], ireg[3]});
      chk($sformatf("rnd%0d_pc", t), pc, ipc);
      chk($sformatf("rnd%0d_halt", t), bus.Halted, hlt);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== im[i]) bad++;
      chk($sformatf("rnd%0d_mem_diffs", t), bad, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
